tpu_host_dma: RTL

- Host-side initiator/responder at the far end of the TPU global-buffer interface.
- Streams operand words from the host into the A and B buffers, pulses the TPU's in_valid with K/M/N, and waits for busy to rise then fall.
- Then reads the C buffer and streams 128-bit result rows back to the host over valid/ready.
- Owns the buffer ports whenever the TPU is not computing; buf_owner drives the integration mux.

---
 rtl/tpu_dma_pkg.sv | 39 +++
 rtl/tpu_dma_rdq.sv | 99 +++++++++
 rtl/tpu_host_dma.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/tpu_dma_pkg.sv
`default_nettype none
// ============================================================================
// tpu_dma_pkg : shared state encoding, size defaults and helpers for the
//               TPU host DMA.
// Rev 1.0
// ============================================================================
package tpu_dma_pkg;

  localparam int AW_DEF = 16;
  localparam int IW_DEF = 32;
  localparam int OW_DEF = 128;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD_A  = 3'd1;
  localparam logic [2:0] ST_LOAD_B  = 3'd2;
  localparam logic [2:0] ST_KICK    = 3'd3;
  localparam logic [2:0] ST_WAIT_HI = 3'd4;
  localparam logic [2:0] ST_WAIT_LO = 3'd5;
  localparam logic [2:0] ST_DRAIN   = 3'd6;
  localparam logic [2:0] ST_DONE    = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_LOAD_A  = ST_LOAD_A,
    S_LOAD_B  = ST_LOAD_B,
    S_KICK    = ST_KICK,
    S_WAIT_HI = ST_WAIT_HI,
    S_WAIT_LO = ST_WAIT_LO,
    S_DRAIN   = ST_DRAIN,
    S_DONE    = ST_DONE
  } state_t;

  // Number of 4-lane words needed to hold x elements.
  function automatic logic [15:0] ceil4(input logic [7:0] x);
    return (16'(x) + 16'd3) >> 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tpu_dma_rdq.sv
`default_nettype none
// ============================================================================
// tpu_dma_rdq : C-buffer read issue plus output register (DEPTH=1) or
//               2-entry prefetch FIFO (DEPTH=2) feeding the result stream.
// Rev 1.0
// ============================================================================
module tpu_dma_rdq
  import tpu_dma_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int OW    = OW_DEF,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic [15:0]   i_nc,
  output logic [AW-1:0] o_c_index,
  input  logic [OW-1:0] i_c_data,
  output logic          o_m_valid,
  input  logic          i_m_ready,
  output logic [OW-1:0] o_m_data,
  output logic          o_m_last,
  output logic          o_last_hs
);

  logic [15:0] r_issued;
  logic [15:0] r_popped;
  logic        r_infl;
  logic [1:0]  r_occ;
  logic        w_pop;
  logic        w_issue;
  logic [2:0]  w_level;

  assign o_m_valid = (r_occ != 2'd0);
  assign w_pop     = o_m_valid && i_m_ready;
  // Occupancy the slot will have once this cycle's pop and arriving read settle.
  assign w_level   = {1'b0, r_occ} + {2'b00, r_infl} - {2'b00, w_pop};
  assign w_issue   = i_en && (r_issued < i_nc) && (w_level < 3'(DEPTH));
  // After the final read the address parks on the last row rather than NC.
  assign o_c_index = AW'(((r_issued == i_nc) && (r_issued != 16'd0)) ?
                         (r_issued - 16'd1) : r_issued);
  assign o_m_last  = o_m_valid && (r_popped == (i_nc - 16'd1));
  assign o_last_hs = w_pop && o_m_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issued <= 16'd0;
      r_popped <= 16'd0;
      r_infl   <= 1'b0;
      r_occ    <= 2'd0;
    end else if (!i_en) begin
      r_issued <= 16'd0;
      r_popped <= 16'd0;
      r_infl   <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      r_infl <= w_issue;
      if (w_issue) r_issued <= r_issued + 16'd1;
      if (w_pop)   r_popped <= r_popped + 16'd1;
      r_occ <= r_occ + {1'b0, r_infl} - {1'b0, w_pop};
    end
  end

  generate
    if (DEPTH == 1) begin : g_reg1
      logic [OW-1:0] r_row;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_row <= '0;
        else if (r_infl) r_row <= i_c_data;
      end
      assign o_m_data = r_row;
    end else begin : g_fifo2
      logic [OW-1:0] r_mem [2];
      logic          r_wp;
      logic          r_rp;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mem[0] <= '0;
          r_mem[1] <= '0;
          r_wp     <= 1'b0;
          r_rp     <= 1'b0;
        end else if (!i_en) begin
          r_wp <= 1'b0;
          r_rp <= 1'b0;
        end else begin
          if (r_infl) begin
            r_mem[r_wp] <= i_c_data;
            r_wp        <= ~r_wp;
          end
          if (w_pop) r_rp <= ~r_rp;
        end
      end
      assign o_m_data = r_mem[r_rp];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/tpu_host_dma.sv
`default_nettype none
// ============================================================================
// tpu_host_dma : host-side loader/drainer for the TPU global buffers.
//                Define TPU_DMA_PREFETCH_EN for the 1 row/cycle prefetch drain.
// Rev 1.0
// ============================================================================
module tpu_host_dma
  import tpu_dma_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int IW = IW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [7:0]    i_cfg_k,
  input  logic [7:0]    i_cfg_m,
  input  logic [7:0]    i_cfg_n,
  input  logic          i_s_valid,
  output logic          o_s_ready,
  input  logic [IW-1:0] i_s_data,
  output logic          o_m_valid,
  input  logic          i_m_ready,
  output logic [OW-1:0] o_m_data,
  output logic          o_m_last,
  output logic          o_done,
  output logic          o_buf_owner,
  output logic          o_tpu_in_valid,
  output logic [7:0]    o_tpu_k,
  output logic [7:0]    o_tpu_m,
  output logic [7:0]    o_tpu_n,
  input  logic          i_tpu_busy,
  output logic          o_a_wr_en,
  output logic          o_b_wr_en,
  output logic [AW-1:0] o_a_index,
  output logic [AW-1:0] o_b_index,
  output logic [IW-1:0] o_a_data_in,
  output logic [IW-1:0] o_b_data_in,
  output logic [AW-1:0] o_c_index,
  input  logic [OW-1:0] i_c_data_out
);

`ifdef TPU_DMA_PREFETCH_EN
  localparam int RDQ_DEPTH = 2;
`else
  localparam int RDQ_DEPTH = 1;
`endif

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_cnt;
  logic [15:0]   r_na;
  logic [15:0]   r_nb;
  logic [15:0]   r_nc;
  logic [7:0]    r_k;
  logic [7:0]    r_m;
  logic [7:0]    r_n;
  logic [7:0]    r_tpu_k;
  logic [7:0]    r_tpu_m;
  logic [7:0]    r_tpu_n;
  logic          r_a_wr_en;
  logic          r_b_wr_en;
  logic [AW-1:0] r_a_index;
  logic [AW-1:0] r_b_index;
  logic [IW-1:0] r_a_data;
  logic [IW-1:0] r_b_data;
  logic          r_done;
  logic          w_s_hs;
  logic          w_last_a;
  logic          w_last_b;
  logic          w_zero;
  logic          w_drain_done;

  assign o_s_ready    = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
  assign w_s_hs       = i_s_valid && o_s_ready;
  assign w_last_a     = (r_cnt == (r_na - 16'd1));
  assign w_last_b     = (r_cnt == (r_nb - 16'd1));
  assign w_zero       = (i_cfg_k == 8'd0) || (i_cfg_m == 8'd0) || (i_cfg_n == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_next = w_zero ? S_DONE : S_LOAD_A;
      S_LOAD_A:  if (w_s_hs && w_last_a) w_next = S_LOAD_B;
      S_LOAD_B:  if (w_s_hs && w_last_b) w_next = S_KICK;
      S_KICK:    w_next = S_WAIT_HI;
      S_WAIT_HI: if (i_tpu_busy) w_next = S_WAIT_LO;
      S_WAIT_LO: if (!i_tpu_busy) w_next = S_DRAIN;
      S_DRAIN:   if (w_drain_done) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 16'd0;
      r_na      <= 16'd0;
      r_nb      <= 16'd0;
      r_nc      <= 16'd0;
      r_k       <= 8'd0;
      r_m       <= 8'd0;
      r_n       <= 8'd0;
      r_tpu_k   <= 8'd0;
      r_tpu_m   <= 8'd0;
      r_tpu_n   <= 8'd0;
      r_a_wr_en <= 1'b0;
      r_b_wr_en <= 1'b0;
      r_a_index <= '0;
      r_b_index <= '0;
      r_a_data  <= '0;
      r_b_data  <= '0;
      r_done    <= 1'b0;
    end else begin
      r_a_wr_en <= 1'b0;
      r_b_wr_en <= 1'b0;
      r_done    <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_k   <= i_cfg_k;
            r_m   <= i_cfg_m;
            r_n   <= i_cfg_n;
            r_na  <= 16'(i_cfg_k) * ceil4(i_cfg_m);
            r_nb  <= 16'(i_cfg_k) * ceil4(i_cfg_n);
            r_nc  <= 16'(i_cfg_m) * ceil4(i_cfg_n);
            r_cnt <= 16'd0;
          end
        end
        S_LOAD_A: begin
          if (w_s_hs) begin
            r_a_wr_en <= 1'b1;
            r_a_index <= AW'(r_cnt);
            r_a_data  <= i_s_data;
            r_cnt     <= w_last_a ? 16'd0 : (r_cnt + 16'd1);
          end
        end
        S_LOAD_B: begin
          if (w_s_hs) begin
            r_b_wr_en <= 1'b1;
            r_b_index <= AW'(r_cnt);
            r_b_data  <= i_s_data;
            r_cnt     <= w_last_b ? 16'd0 : (r_cnt + 16'd1);
            // Dimensions go out together with the kick pulse and stay put.
            if (w_last_b) begin
              r_tpu_k <= r_k;
              r_tpu_m <= r_m;
              r_tpu_n <= r_n;
            end
          end
        end
        default: ;
      endcase
    end
  end

  tpu_dma_rdq #(
    .AW    (AW),
    .OW    (OW),
    .DEPTH (RDQ_DEPTH)
  ) u_rdq (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (r_state == S_DRAIN),
    .i_nc      (r_nc),
    .o_c_index (o_c_index),
    .i_c_data  (i_c_data_out),
    .o_m_valid (o_m_valid),
    .i_m_ready (i_m_ready),
    .o_m_data  (o_m_data),
    .o_m_last  (o_m_last),
    .o_last_hs (w_drain_done)
  );

  assign o_done         = r_done;
  assign o_tpu_in_valid = (r_state == S_KICK);
  assign o_buf_owner    = (r_state == S_KICK) || (r_state == S_WAIT_HI) ||
                          (r_state == S_WAIT_LO);
  assign o_tpu_k        = r_tpu_k;
  assign o_tpu_m        = r_tpu_m;
  assign o_tpu_n        = r_tpu_n;
  assign o_a_wr_en      = r_a_wr_en;
  assign o_b_wr_en      = r_b_wr_en;
  assign o_a_index      = r_a_index;
  assign o_b_index      = r_b_index;
  assign o_a_data_in    = r_a_data;
  assign o_b_data_in    = r_b_data;

endmodule
`default_nettype wire
